// File: rtl/maze_walker.sv
// maze_walker: depth-first solver for a 16x16 single-bit maze memory.
// Walks from (0,0) to (15,15), marking visited cells with 1 and keeping a
// 2-bit direction stack for backtracking. The memory read path is
// combinational: mem_dout is valid in the same cycle mem_rd is raised.
// Optional feature macro: MAZE_WALKER_PATH_DUMP_EN streams the solved path
// on path_valid/path_x/path_y before DONE.
module maze_walker #(
  parameter int STACK_DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mem_dout,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       mem_din,
  output logic [3:0] mem_x,
  output logic [3:0] mem_y,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic       path_valid,
  output logic [3:0] path_x,
  output logic [3:0] path_y
);

  localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SPW = $clog2(STACK_DEPTH + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHK0, S_MARK, S_CHECK, S_MOVE, S_BACK, S_DONE, S_FAIL
`ifdef MAZE_WALKER_PATH_DUMP_EN
    , S_DUMP
`endif
  } state_t;

  state_t           state, state_n;
  logic [3:0]       cur_x, cur_y, cur_x_n, cur_y_n;
  logic [1:0]       dir, dir_n;
  logic [SPW-1:0]   sp, sp_n, spm1;
  logic [1:0]       stk [STACK_DEPTH];
  logic             push;
  logic [1:0]       pop_d;
  logic             nb_ok;
  logic [7:0]       nb, bk;
  logic [1:0]       rsync;
  logic             rst_i_n;

  // One cell step in direction d (0=down,1=right,2=up,3=left), no bounds check
  function automatic logic [7:0] step(input logic [3:0] x, input logic [3:0] y,
                                      input logic [1:0] d);
    logic [3:0] nx, ny;
    nx = x;
    ny = y;
    case (d)
      2'd0: nx = x + 4'd1;
      2'd1: ny = y + 4'd1;
      2'd2: nx = x - 4'd1;
      default: ny = y - 4'd1;
    endcase
    return {nx, ny};
  endfunction

  // Reset asserts at once but releases two clean edges later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsync <= 2'b00;
    else        rsync <= {rsync[0], 1'b1};
  end
  assign rst_i_n = rsync[1];

  // Neighbour in the current try direction, checked against the edges first
  always_comb begin
    case (dir)
      2'd0:    nb_ok = (cur_x != 4'd15);
      2'd1:    nb_ok = (cur_y != 4'd15);
      2'd2:    nb_ok = (cur_x != 4'd0);
      default: nb_ok = (cur_y != 4'd0);
    endcase
  end
  assign nb    = step(cur_x, cur_y, dir);
  assign spm1  = sp - SPW'(1);
  assign pop_d = stk[spm1[AW-1:0]];
  // Opposite direction is d xor 2 (down<->up, right<->left)
  assign bk    = step(cur_x, cur_y, pop_d ^ 2'b10);

`ifdef MAZE_WALKER_PATH_DUMP_EN
  logic [SPW-1:0] di, di_n;
  logic [3:0]     px, py, px_n, py_n;
  logic [7:0]     dstep;
  assign dstep = step(px, py, stk[di[AW-1:0]]);
`endif

  // Next-state, datapath next values and memory strobes
  always_comb begin
    state_n = state;
    cur_x_n = cur_x;
    cur_y_n = cur_y;
    dir_n   = dir;
    sp_n    = sp;
    push    = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    mem_x   = 4'd0;
    mem_y   = 4'd0;
`ifdef MAZE_WALKER_PATH_DUMP_EN
    di_n = di;
    px_n = px;
    py_n = py;
`endif
    case (state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_n = S_CHK0;
          cur_x_n = 4'd0;
          cur_y_n = 4'd0;
          dir_n   = 2'd0;
          sp_n    = '0;
        end
      end
      S_CHK0: begin
        mem_rd  = 1'b1;
        state_n = mem_dout ? S_FAIL : S_MARK;
      end
      S_MARK: begin
        mem_wr = 1'b1;
        mem_x  = cur_x;
        mem_y  = cur_y;
        if (cur_x == 4'd15 && cur_y == 4'd15) begin
`ifdef MAZE_WALKER_PATH_DUMP_EN
          state_n = S_DUMP;
          di_n    = '0;
          px_n    = 4'd0;
          py_n    = 4'd0;
`else
          state_n = S_DONE;
`endif
        end else begin
          state_n = S_CHECK;
          dir_n   = 2'd0;
        end
      end
      S_CHECK: begin
        if (nb_ok) begin
          mem_rd = 1'b1;
          mem_x  = nb[7:4];
          mem_y  = nb[3:0];
        end
        if (nb_ok && !mem_dout) state_n = S_MOVE;
        else if (dir == 2'd3)   state_n = S_BACK;
        else                    dir_n   = dir + 2'd1;
      end
      S_MOVE: begin
        if (sp == SPW'(STACK_DEPTH)) begin
          state_n = S_FAIL;
        end else begin
          push    = 1'b1;
          sp_n    = sp + SPW'(1);
          cur_x_n = nb[7:4];
          cur_y_n = nb[3:0];
          state_n = S_MARK;
        end
      end
      S_BACK: begin
        if (sp == '0) begin
          state_n = S_FAIL;
        end else begin
          sp_n    = spm1;
          cur_x_n = bk[7:4];
          cur_y_n = bk[3:0];
          if (pop_d != 2'd3) begin
            state_n = S_CHECK;
            dir_n   = pop_d + 2'd1;
          end
        end
      end
`ifdef MAZE_WALKER_PATH_DUMP_EN
      S_DUMP: begin
        if (di == sp) begin
          state_n = S_DONE;
        end else begin
          px_n = dstep[7:4];
          py_n = dstep[3:0];
          di_n = di + SPW'(1);
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  assign mem_din = mem_wr;
  assign busy    = !(state == S_IDLE || state == S_DONE || state == S_FAIL);
  assign done    = (state == S_DONE);
  assign fail    = (state == S_FAIL);

`ifdef MAZE_WALKER_PATH_DUMP_EN
  assign path_valid = (state == S_DUMP);
  assign path_x     = path_valid ? px : 4'd0;
  assign path_y     = path_valid ? py : 4'd0;
`else
  assign path_valid = 1'b0;
  assign path_x     = 4'd0;
  assign path_y     = 4'd0;
`endif

  // State and walker registers
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state <= S_IDLE;
      cur_x <= 4'd0;
      cur_y <= 4'd0;
      dir   <= 2'd0;
      sp    <= '0;
    end else begin
      state <= state_n;
      cur_x <= cur_x_n;
      cur_y <= cur_y_n;
      dir   <= dir_n;
      sp    <= sp_n;
    end
  end

`ifdef MAZE_WALKER_PATH_DUMP_EN
  // Replay cursor for the path stream
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      di <= '0;
      px <= 4'd0;
      py <= 4'd0;
    end else begin
      di <= di_n;
      px <= px_n;
      py <= py_n;
    end
  end
`endif

  // Direction stack storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push) stk[sp[AW-1:0]] <= dir;
  end

endmodule

// File: tb/tb_maze_walker.sv
// Directed bench for maze_walker with a behavioural 16x16 maze memory.
module tb_maze_walker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       mem_dout;
  logic       mem_rd, mem_wr, mem_din;
  logic [3:0] mem_x, mem_y;
  logic       busy, done, fail, path_valid;
  logic [3:0] path_x, path_y;

  logic [255:0] mem, img;
  logic         ld = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;

  // monitor state
  int         viol = 0;
  int         wr_cnt = 0;
  int         jumps = 0;
  int         pv_cnt = 0;
  logic       have_last = 1'b0;
  logic [3:0] last_x = 4'd0, last_y = 4'd0;
  logic [3:0] pvx [64];
  logic [3:0] pvy [64];

  maze_walker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_dout(mem_dout),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din),
    .mem_x(mem_x), .mem_y(mem_y), .busy(busy), .done(done), .fail(fail),
    .path_valid(path_valid), .path_x(path_x), .path_y(path_y)
  );

  always #5 clk = ~clk;

  // maze memory: combinational read, write on the clock
  always @(posedge clk) begin
    if (ld)          mem <= img;
    else if (mem_wr) mem[{mem_x, mem_y}] <= mem_din;
  end
  assign mem_dout = mem_rd ? mem[{mem_x, mem_y}] : 1'b0;

  // per-cycle protocol monitor plus write/path logging
  always @(negedge clk) begin
    if (mem_rd && mem_wr) viol <= viol + 1;
    if ((mem_rd || mem_wr) && ($isunknown(mem_x) || $isunknown(mem_y))) viol <= viol + 1;
    if (start) begin
      wr_cnt <= 0; jumps <= 0; pv_cnt <= 0; have_last <= 1'b0;
    end else begin
      if (mem_wr) begin
        wr_cnt <= wr_cnt + 1;
        if (have_last && (((mem_x > last_x ? mem_x - last_x : last_x - mem_x) +
                           (mem_y > last_y ? mem_y - last_y : last_y - mem_y)) != 4'd1))
          jumps <= jumps + 1;
        last_x <= mem_x; last_y <= mem_y; have_last <= 1'b1;
      end
      if (path_valid) begin
        if (pv_cnt < 64) begin pvx[pv_cnt] <= path_x; pvy[pv_cnt] <= path_y; end
        pv_cnt <= pv_cnt + 1;
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic pulse_start(); start = 1'b1; tick(); start = 1'b0; endtask

  task automatic load(input logic [255:0] m); img = m; ld = 1'b1; tick(); ld = 1'b0; endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic wait_end(input string nm);
    int i;
    for (i = 0; i < 5000 && !(done || fail); i++) @(negedge clk);
    n_cmp++;
    if (!(done || fail)) begin n_mis++; $display("FAIL %s timeout: no done/fail after %0d cycles", nm, i); end
  endtask

  function automatic int count_rows(input int r0, input int r1);
    int c = 0;
    for (int x = r0; x <= r1; x++)
      for (int y = 0; y < 16; y++) if (mem[x*16 + y]) c++;
    return c;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; #3;
    n_cmp++;
    if ({mem_rd, mem_wr, mem_din, mem_x, mem_y, busy, done, fail, path_valid, path_x, path_y} !== 23'd0) begin
      n_mis++; $display("FAIL reset_outputs: got %h want 0",
        {mem_rd, mem_wr, mem_din, mem_x, mem_y, busy, done, fail, path_valid, path_x, path_y});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if ({busy, done, fail, mem_rd, mem_wr} !== 5'd0) begin
      n_mis++; $display("FAIL reset_idle: got %b want 00000", {busy, done, fail, mem_rd, mem_wr});
    end
  endtask

  task automatic check_path(input string nm, input int dead_end);
    int bad = 0;
    int ex, ey;
`ifdef MAZE_WALKER_PATH_DUMP_EN
    n_cmp++;
    if (pv_cnt !== 31) begin n_mis++; $display("FAIL %s path_len: got %0d want 31", nm, pv_cnt); end
    for (int i = 0; i < 31; i++) begin
      if (dead_end != 0) begin ex = (i <= 15) ? 0 : i - 15; ey = (i <= 15) ? i : 15; end
      else               begin ex = (i <= 15) ? i : 15;     ey = (i <= 15) ? 0 : i - 15; end
      if (pvx[i] !== 4'(ex) || pvy[i] !== 4'(ey)) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_mis++; $display("FAIL %s path_cells: got %0d wrong cells want 0", nm, bad); end
`else
    n_cmp++;
    if (pv_cnt !== 0) begin n_mis++; $display("FAIL %s path_off: got %0d valid cycles want 0", nm, pv_cnt); end
`endif
  endtask

  task automatic test_open_maze();
    int c;
    load('0);
    pulse_start();
    @(negedge clk);
    n_cmp++;
    if ({busy, mem_rd, mem_wr, mem_x, mem_y} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      n_mis++; $display("FAIL open_chk0: got %h want %h", {busy, mem_rd, mem_wr, mem_x, mem_y}, {1'b1, 1'b1, 1'b0, 8'h00});
    end
    wait_end("open");
    n_cmp++;
    if ({done, fail, busy} !== 3'b100) begin n_mis++; $display("FAIL open_status: got %b want 100", {done, fail, busy}); end
    n_cmp++;
    if (wr_cnt !== 31) begin n_mis++; $display("FAIL open_writes: got %0d want 31", wr_cnt); end
    n_cmp++;
    if (jumps !== 0) begin n_mis++; $display("FAIL open_jumps: got %0d want 0", jumps); end
    c = 0;
    for (int i = 0; i < 16; i++) begin
      if (mem[i*16]) c++;
      if (i > 0 && mem[15*16 + i]) c++;
    end
    n_cmp++;
    if (c !== 31 || count_rows(0, 15) !== 31) begin
      n_mis++; $display("FAIL open_marks: got %0d/%0d want 31/31", c, count_rows(0, 15));
    end
    check_path("open", 0);
    repeat (3) tick();
    n_cmp++;
    if ({done, fail, busy} !== 3'b100) begin n_mis++; $display("FAIL open_hold: got %b want 100", {done, fail, busy}); end
  endtask

  // memory left visited: restarting from DONE sees (0,0)=1 and fails
  task automatic test_restart_from_done();
    pulse_start();
    @(negedge clk);
    n_cmp++;
    if ({busy, done, fail} !== 3'b100) begin n_mis++; $display("FAIL restart_busy: got %b want 100", {busy, done, fail}); end
    tick();
    n_cmp++;
    if ({busy, done, fail} !== 3'b001) begin n_mis++; $display("FAIL restart_fail: got %b want 001", {busy, done, fail}); end
  endtask

  task automatic test_wall_start();
    logic [255:0] m;
    m = '0; m[0] = 1'b1;
    load(m);
    pulse_start();
    @(negedge clk);
    n_cmp++;
    if ({busy, fail} !== 2'b10) begin n_mis++; $display("FAIL wall_cycle1: got %b want 10", {busy, fail}); end
    tick();
    n_cmp++;
    if ({busy, fail, done} !== 3'b010) begin n_mis++; $display("FAIL wall_cycle2: got %b want 010", {busy, fail, done}); end
    n_cmp++;
    if (wr_cnt !== 0) begin n_mis++; $display("FAIL wall_nowrite: got %0d want 0", wr_cnt); end
  endtask

  task automatic test_row8_wall();
    logic [255:0] m;
    m = '0;
    for (int y = 0; y < 16; y++) m[8*16 + y] = 1'b1;
    load(m);
    pulse_start();
    wait_end("row8");
    n_cmp++;
    if ({done, fail} !== 2'b01) begin n_mis++; $display("FAIL row8_status: got %b want 01", {done, fail}); end
    n_cmp++;
    if (count_rows(0, 7) !== 128) begin n_mis++; $display("FAIL row8_upper: got %0d want 128", count_rows(0, 7)); end
    n_cmp++;
    if (count_rows(9, 15) !== 0) begin n_mis++; $display("FAIL row8_lower: got %0d want 0", count_rows(9, 15)); end
    n_cmp++;
    if (wr_cnt !== 128) begin n_mis++; $display("FAIL row8_writes: got %0d want 128", wr_cnt); end
  endtask

  // row 0 open, column 1 dead end down to row 10, column 15 open to the goal
  task automatic test_dead_end();
    logic [255:0] m;
    m = '1;
    for (int y = 0; y < 16; y++) m[y] = 1'b0;
    for (int x = 0; x <= 10; x++) m[x*16 + 1] = 1'b0;
    for (int x = 0; x < 16; x++) m[x*16 + 15] = 1'b0;
    load(m);
    pulse_start();
    wait_end("deadend");
    n_cmp++;
    if ({done, fail} !== 2'b10) begin n_mis++; $display("FAIL deadend_status: got %b want 10", {done, fail}); end
    n_cmp++;
    if (jumps !== 1) begin n_mis++; $display("FAIL deadend_backtrack: got %0d jumps want 1", jumps); end
    n_cmp++;
    if (wr_cnt !== 41) begin n_mis++; $display("FAIL deadend_writes: got %0d want 41", wr_cnt); end
    check_path("deadend", 1);
  endtask

  task automatic test_start_while_busy();
    load('0);
    pulse_start();
    repeat (20) tick();
    n_cmp++;
    if (busy !== 1'b1) begin n_mis++; $display("FAIL busy_mid: got %b want 1", busy); end
    pulse_start();
    wait_end("busystart");
    n_cmp++;
    if ({done, fail} !== 2'b10) begin n_mis++; $display("FAIL busy_ignored: got %b want 10", {done, fail}); end
  endtask

  task automatic test_reset_mid();
    load('0);
    pulse_start();
    tick();
    tick();
    n_cmp++;
    if ({mem_rd, mem_wr, mem_x, mem_y} !== {1'b1, 1'b0, 4'd1, 4'd0}) begin
      n_mis++; $display("FAIL midrst_check: got %h want %h", {mem_rd, mem_wr, mem_x, mem_y}, {1'b1, 1'b0, 4'd1, 4'd0});
    end
    rst_n = 1'b0; #1;
    n_cmp++;
    if ({mem_rd, mem_wr, mem_din, mem_x, mem_y, busy, done, fail, path_valid, path_x, path_y} !== 23'd0) begin
      n_mis++; $display("FAIL midrst_outputs: got %h want 0",
        {mem_rd, mem_wr, mem_din, mem_x, mem_y, busy, done, fail, path_valid, path_x, path_y});
    end
    tick();
    do_reset();
    load('0);
    pulse_start();
    wait_end("midrst");
    n_cmp++;
    if ({done, fail} !== 2'b10) begin n_mis++; $display("FAIL midrst_resolve: got %b want 10", {done, fail}); end
    n_cmp++;
    if (wr_cnt !== 31) begin n_mis++; $display("FAIL midrst_writes: got %0d want 31", wr_cnt); end
  endtask

  task automatic test_protocol();
    n_cmp++;
    if (viol !== 0) begin n_mis++; $display("FAIL protocol: got %0d violations want 0", viol); end
  endtask

  initial begin
    mem = '0; img = '0;
    #2;
    test_reset();
    test_open_maze();
    test_restart_from_done();
    test_wall_start();
    test_row8_wall();
    test_dead_end();
    test_start_while_busy();
    test_reset_mid();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/maze_walker.md
MAZE_WALKER -- requirements
Module: maze_walker

Interface
REQ-001 Parameter STACK_DEPTH, default 256, number of 2-bit direction entries in the backtrack stack.
REQ-002 clk  input  1  rising-edge clock shared with the maze memory.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle pulse that begins a solve; ignored unless in IDLE.
REQ-005 mem_dout  input  1  cell value from memory; 1 = wall or visited, 0 = free; sampled only while mem_rd=1.
REQ-006 mem_rd  output  1  memory read enable.
REQ-007 mem_wr  output  1  memory write enable.
REQ-008 mem_din  output  1  write data; always 1 when mem_wr=1.
REQ-009 mem_x, mem_y  output  4 each  cell address (row, column).
REQ-010 busy, done, fail  output  1 each  status flags.
REQ-011 path_valid  output  1, path_x / path_y  output  4 each  solved-path stream (see Configuration).

Function
REQ-012 Start cell is (0,0) and goal cell is (15,15); the current position is held in cur_x/cur_y.
REQ-013 States: IDLE, CHK0, MARK, CHECK, MOVE, BACK, DONE, FAIL, plus DUMP when enabled.
REQ-014 IDLE with start=1 -> CHK0, with cur=(0,0), dir=0, stack empty, busy=1.
REQ-015 CHK0 -> mem_rd=1 at (0,0); if mem_dout=1 go to FAIL, otherwise go to MARK.
REQ-016 MARK -> mem_wr=1, mem_din=1 at cur for exactly one cycle; if cur=(15,15) go to DONE, otherwise go to CHECK with dir=0.
REQ-017 Direction encoding: 0=down (x+1), 1=right (y+1), 2=up (x-1), 3=left (y-1); directions are tried in ascending order.
REQ-018 CHECK consumes one cycle per direction and is handled as follows:
- If the neighbour is in bounds: mem_rd=1 with the neighbour address; mem_dout=0 -> MOVE, mem_dout=1 -> dir+1.
- If the neighbour is out of bounds: no read is issued, and dir+1.
- After dir=3 fails: go to BACK.
REQ-019 MOVE -> push dir, cur takes the neighbour address, then go to MARK; latency is 1 cycle.
REQ-020 BACK with the stack empty -> FAIL.
REQ-021 BACK otherwise -> pop d, cur steps opposite to d; if d=3 stay in BACK, otherwise go to CHECK with dir=d+1.
REQ-022 mem_rd and mem_wr are never both 1 in the same cycle; both are 0 outside CHK0, MARK and CHECK.
REQ-023 Stack overflow (a push when the stack is full) -> FAIL; with STACK_DEPTH >= 255 this cannot occur on a 16x16 maze.
REQ-024 DONE and FAIL hold done or fail at 1 with busy=0 until the next start; a start from DONE or FAIL re-enters CHK0 (memory is not cleared by the block).
REQ-025 A start pulse while busy=1 is ignored.
REQ-026 Coordinate arithmetic is 4-bit; bounds are checked before the step so addresses never wrap.

Reset
REQ-027 rst_n=0 forces IDLE immediately, regardless of clock.
REQ-028 Reset values: mem_rd=0, mem_wr=0, mem_din=0, mem_x=0, mem_y=0, busy=0, done=0, fail=0, path_valid=0, path_x=0, path_y=0, stack pointer=0.
REQ-029 Reset asserted mid-solve aborts the solve at once; no write is issued after the edge.
REQ-030 Release of rst_n is synchronised in the design so the first active edge is clean.

Configuration
REQ-031 Macro MAZE_WALKER_PATH_DUMP_EN controls the solved-path stream.
REQ-032 With MAZE_WALKER_PATH_DUMP_EN defined, the path is dumped as follows:
- MARK at the goal -> DUMP instead of DONE.
- DUMP replays the stack from bottom to top, one cell per cycle, starting at (0,0) and ending at (15,15).
- path_valid=1 for (stack entries + 1) cycles, then the state goes to DONE.
REQ-033 Without MAZE_WALKER_PATH_DUMP_EN, the DUMP state is absent and path_valid, path_x and path_y are tied to 0.

Verification
REQ-034 All-zero maze, start -> done=1 and fail=0; with dump enabled, 31 path_valid cycles following column 0 down to (15,0), then row 15 right to (15,15).
REQ-035 Memory cell (0,0)=1, start -> fail=1 exactly 2 cycles after start, with no mem_wr pulse.
REQ-036 Row 8 entirely walls, start -> fail=1; every free cell in rows 0..7 has been written to 1.
REQ-037 A dead-end corridor at column 1 with the open route via column 15 -> BACK pops observed, and done=1 is reached.
REQ-038 rst_n is pulsed low during CHECK -> all outputs read 0 in the same cycle; a later start solves normally.
REQ-039 Every cycle is checked for no mem_rd and mem_wr overlap, and for mem_x and mem_y staying within 0..15 whenever mem_rd or mem_wr is 1.
